// File: rtl/register_8bit.sv
// Parallel-load register: captures D on every rising edge, synchronous active-high reset.
// Define REGISTER_8BIT_PARITY_EN to add a registered even-parity output q_parity.
module register_8bit #(
   parameter int unsigned           WIDTH       = 8,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
`ifdef REGISTER_8BIT_PARITY_EN
   output logic [WIDTH-1:0] Q,
   output logic             q_parity
`else
   output logic [WIDTH-1:0] Q
`endif
);

   always_ff @(posedge clk) begin
      if (reset) begin
         Q <= RESET_VALUE;
      end else begin
         Q <= D;
      end
   end

`ifdef REGISTER_8BIT_PARITY_EN
   // Parity is computed from the loaded value so it always tracks ^Q after an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_parity <= ^RESET_VALUE;
      end else begin
         q_parity <= ^D;
      end
   end
`endif

endmodule

// File: tb/tb_register_8bit.sv
// Directed self-checking bench for register_8bit; clk period 10 ns, rising edges at 5, 15, 25, ...
module tb_register_8bit;

   logic       clk;
   logic       reset;
   logic [7:0] D;
   logic [7:0] Q;
`ifdef REGISTER_8BIT_PARITY_EN
   logic       q_parity;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   register_8bit #(
      .WIDTH       (8),
      .RESET_VALUE (8'h00)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .D        (D),
`ifdef REGISTER_8BIT_PARITY_EN
      .q_parity (q_parity),
`endif
      .Q        (Q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      // Edge at 5 ns with reset high
      @(posedge clk); #1;
      n_checks++;
      if (Q !== 8'h00) begin
         n_fails++;
         $display("FAIL reset_load: Q=%h expected %h at %0t", Q, 8'h00, $time);
      end
`ifdef REGISTER_8BIT_PARITY_EN
      n_checks++;
      if (q_parity !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_parity: q_parity=%b expected 0 at %0t", q_parity, $time);
      end
`endif
      #4 reset = 1'b0;   // t=10
      @(posedge clk); #1; // edge at 15, D still 00
      n_checks++;
      if (Q !== 8'h00) begin
         n_fails++;
         $display("FAIL reset_hold: Q=%h expected %h at %0t", Q, 8'h00, $time);
      end
      #4 D = 8'hAA;       // t=20
      @(posedge clk); #1; // edge at 25
      n_checks++;
      if (Q !== 8'hAA) begin
         n_fails++;
         $display("FAIL load_aa: Q=%h expected %h at %0t", Q, 8'hAA, $time);
      end
`ifdef REGISTER_8BIT_PARITY_EN
      n_checks++;
      if (q_parity !== 1'b0) begin
         n_fails++;
         $display("FAIL parity_aa: q_parity=%b expected 0 at %0t", q_parity, $time);
      end
`endif
   endtask

   task automatic test_midcycle();
      #4 D = 8'hF0;       // t=30
      #2 D = 8'h3C;       // t=32
      n_checks++;
      if (Q !== 8'hAA) begin
         n_fails++;
         $display("FAIL midcycle_glitch: Q=%h expected %h at %0t", Q, 8'hAA, $time);
      end
      #1 D = 8'hF0;       // t=33
      n_checks++;
      if (Q !== 8'hAA) begin
         n_fails++;
         $display("FAIL midcycle_restore: Q=%h expected %h at %0t", Q, 8'hAA, $time);
      end
      @(posedge clk); #1; // edge at 35
      n_checks++;
      if (Q !== 8'hF0) begin
         n_fails++;
         $display("FAIL load_f0: Q=%h expected %h at %0t", Q, 8'hF0, $time);
      end
`ifdef REGISTER_8BIT_PARITY_EN
      n_checks++;
      if (q_parity !== 1'b0) begin
         n_fails++;
         $display("FAIL parity_f0: q_parity=%b expected 0 at %0t", q_parity, $time);
      end
`endif
   endtask

   task automatic test_sync_reset();
      #4 reset = 1'b1;    // t=40, D=F0 held
      #2;
      n_checks++;
      if (Q !== 8'hF0) begin
         n_fails++;
         $display("FAIL reset_not_async: Q=%h expected %h at %0t", Q, 8'hF0, $time);
      end
      @(posedge clk); #1; // edge at 45
      n_checks++;
      if (Q !== 8'h00) begin
         n_fails++;
         $display("FAIL reset_priority: Q=%h expected %h at %0t", Q, 8'h00, $time);
      end
   endtask

   task automatic test_release();
      #4;                 // t=50
      reset = 1'b0;
      D     = 8'h0F;
      @(posedge clk); #1; // edge at 55
      n_checks++;
      if (Q !== 8'h0F) begin
         n_fails++;
         $display("FAIL release_load: Q=%h expected %h at %0t", Q, 8'h0F, $time);
      end
`ifdef REGISTER_8BIT_PARITY_EN
      n_checks++;
      if (q_parity !== 1'b0) begin
         n_fails++;
         $display("FAIL parity_0f: q_parity=%b expected 0 at %0t", q_parity, $time);
      end
`endif
      @(posedge clk); #1; // edge at 65
      n_checks++;
      if (Q !== 8'h0F) begin
         n_fails++;
         $display("FAIL release_hold: Q=%h expected %h at %0t", Q, 8'h0F, $time);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vec [6] = '{8'h01, 8'h80, 8'hFF, 8'h55, 8'h7E, 8'h00};
      logic       par [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         #4 D = vec[i];
         @(posedge clk); #1;
         n_checks++;
         if (Q !== vec[i]) begin
            n_fails++;
            $display("FAIL b2b_%0d: Q=%h expected %h at %0t", i, Q, vec[i], $time);
         end
`ifdef REGISTER_8BIT_PARITY_EN
         n_checks++;
         if (q_parity !== par[i]) begin
            n_fails++;
            $display("FAIL b2b_parity_%0d: q_parity=%b expected %b at %0t",
                     i, q_parity, par[i], $time);
         end
`else
         if (par[i] === 1'bx) $display("unexpected parity entry %0d", i);
`endif
      end
      // Reset while D holds all ones must still clear every bit
      #4;
      reset = 1'b1;
      D     = 8'hFF;
      @(posedge clk); #1;
      n_checks++;
      if (Q !== 8'h00) begin
         n_fails++;
         $display("FAIL b2b_reset_ff: Q=%h expected %h at %0t", Q, 8'h00, $time);
      end
      #4 reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (Q !== 8'hFF) begin
         n_fails++;
         $display("FAIL b2b_after_reset: Q=%h expected %h at %0t", Q, 8'hFF, $time);
      end
   endtask

   initial begin
      reset = 1'b1;
      D     = 8'h00;
      test_reset();
      test_midcycle();
      test_sync_reset();
      test_release();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
